// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared types and constants for the sequential restoring divider.
//   state_t      : controller states (IDLE / RUN / FIN)
//   DZ_QUOT_BIT  : fill bit for the quotient on a divide-by-zero (all ones)
//   cnt_width()  : width of the iteration counter for a given operand width
// ---------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam logic DZ_QUOT_BIT = 1'b1;

    // The counter only has to hold W-1, so $clog2(W) bits are enough.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/div_trial_sub.sv
// ---------------------------------------------------------------------------
// div_trial_sub
// Combinational trial subtraction A + ~B + 1 at N bits.
//   i_a     : minuend
//   i_b     : subtrahend
//   o_diff  : N-bit difference
//   o_carry : carry-out of the add; 1 means A >= B (no borrow)
// ---------------------------------------------------------------------------
module div_trial_sub #(
    parameter int N = 5
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_diff,
    output logic         o_carry
);

    localparam logic [N:0] ONE = (N+1)'(1);

    assign {o_carry, o_diff} = {1'b0, i_a} + {1'b0, ~i_b} + ONE;

endmodule

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   i_clk        : rising-edge clock
//   i_rst_n      : asynchronous active-low reset
//   i_start      : operation request, sampled only in IDLE
//   i_data_a     : dividend, captured on the accepting edge
//   i_data_b     : divisor, captured on the accepting edge
//   o_busy       : high in RUN and FIN
//   o_done       : one-cycle pulse in FIN; results valid from then on
//   o_quot       : quotient (all ones on divide-by-zero)
//   o_rem        : remainder (dividend on divide-by-zero)
//   o_dz         : divide-by-zero flag of the last operation
//   o_z          : high when o_quot is zero
//   o_dbg_state  : current controller state
//
// Handshake: a request is accepted on a rising edge where the unit is in
// IDLE and i_start is high; o_busy rises after that edge. Requests while
// busy are dropped, not queued. o_done marks the single cycle in which the
// new results first appear; they then hold until the next o_done.
// ---------------------------------------------------------------------------
module seq_divider
    import div_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [W-1:0] i_data_a,
    input  logic [W-1:0] i_data_b,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_quot,
    output logic [W-1:0] o_rem,
    output logic         o_dz,
    output logic         o_z,
    output state_t       o_dbg_state
);

    localparam int CW = cnt_width(W);

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_q;
    logic [W-1:0]  r_div;
    logic [W:0]    r_rem;
    logic          r_dz_pend;

    logic [W:0]    w_r_shift;
    logic [W:0]    w_trial_diff;
    logic          w_no_borrow;
    logic [W:0]    w_r_next;
    logic [W-1:0]  w_q_next;
    logic          w_last;
    logic          w_unused_rem_msb;

    // {R, Q} shifted left by one; the restored remainder is always below
    // the divisor, so R's top bit is zero and drops out of the shift.
    assign w_r_shift        = {r_rem[W-1:0], r_q[W-1]};
    assign w_unused_rem_msb = r_rem[W];

    div_trial_sub #(.N(W + 1)) u_trial (
        .i_a     (w_r_shift),
        .i_b     ({1'b0, r_div}),
        .o_diff  (w_trial_diff),
        .o_carry (w_no_borrow)
    );

    assign w_r_next = w_no_borrow ? w_trial_diff : w_r_shift;
    assign w_q_next = {r_q[W-2:0], w_no_borrow};
    assign w_last   = (r_cnt == '0);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. A zero divisor also passes through one RUN cycle
    // (counter loaded with 0) so its results land one edge after accept.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_next_state = ST_RUN;
            ST_RUN:  if (w_last)  w_next_state = ST_FIN;
            ST_FIN:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        o_busy      = (r_state == ST_RUN) || (r_state == ST_FIN);
        o_done      = (r_state == ST_FIN);
        o_dbg_state = r_state;
    end

    // Datapath and result registers. Results are written on the edge that
    // enters FIN so they are already valid while o_done is high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_q       <= '0;
            r_div     <= '0;
            r_rem     <= '0;
            r_dz_pend <= 1'b0;
            o_quot    <= '0;
            o_rem     <= '0;
            o_dz      <= 1'b0;
            o_z       <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_q       <= i_data_a;
                        r_div     <= i_data_b;
                        r_rem     <= '0;
                        r_dz_pend <= (i_data_b == '0);
                        r_cnt     <= (i_data_b == '0) ? '0 : CW'(W - 1);
                    end
                end
                ST_RUN: begin
                    if (r_dz_pend) begin
                        // r_q still holds the untouched dividend here.
                        o_quot <= {W{DZ_QUOT_BIT}};
                        o_rem  <= r_q;
                        o_dz   <= 1'b1;
                        o_z    <= 1'b0;
                    end else begin
                        r_q   <= w_q_next;
                        r_rem <= w_r_next;
                        if (w_last) begin
                            o_quot <= w_q_next;
                            o_rem  <= w_r_next[W-1:0];
                            o_dz   <= 1'b0;
                            o_z    <= (w_q_next == '0);
                        end
                    end
                    if (!w_last) begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         i_start;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_quot;
    logic [W-1:0] o_rem;
    logic         o_dz;
    logic         o_z;
    logic [1:0]   o_dbg_state;

    int n_total;
    int n_bad;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    seq_divider #(.W(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (i_start),
        .i_data_a    (i_a),
        .i_data_b    (i_b),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_quot      (o_quot),
        .o_rem       (o_rem),
        .o_dz        (o_dz),
        .o_z         (o_z),
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE, wait for DONE (bounded), capture the
    // results in the DONE cycle, then step one more edge back to IDLE.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int busy_cyc,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output logic z,
                         output logic idle_after);
        i_start = 1'b1;
        i_a     = a;
        i_b     = b;
        tick();
        i_start  = 1'b0;
        i_a      = W'($urandom_range(0, 15));
        i_b      = W'($urandom_range(0, 15));
        lat      = 1;
        busy_cyc = 0;
        while (!o_done && lat < 20) begin
            if (o_busy) busy_cyc++;
            tick();
            lat++;
        end
        if (o_busy) busy_cyc++;
        q  = o_quot;
        r  = o_rem;
        dz = o_dz;
        z  = o_z;
        tick();
        idle_after = !o_done && !o_busy;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n   = 1'b0;
        i_start = 1'b0;
        i_a     = '0;
        i_b     = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n_total++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%0b exp=0", o_busy); end
        n_total++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%0b exp=0", o_done); end
        n_total++; if (o_quot !== 4'd0) begin n_bad++; $display("FAIL reset_quot got=%0d exp=0", o_quot); end
        n_total++; if (o_rem  !== 4'd0) begin n_bad++; $display("FAIL reset_rem got=%0d exp=0", o_rem); end
        n_total++; if (o_dz   !== 1'b0) begin n_bad++; $display("FAIL reset_dz got=%0b exp=0", o_dz); end
        n_total++; if (o_z    !== 1'b1) begin n_bad++; $display("FAIL reset_z got=%0b exp=1", o_z); end
    endtask

    task automatic test_basic();
        int lat, bc;
        logic [W-1:0] q, r;
        logic dz, z, idle;
        do_op(4'd13, 4'd3, lat, bc, q, r, dz, z, idle);
        n_total++; if (lat  !== 5)     begin n_bad++; $display("FAIL basic_latency got=%0d exp=5", lat); end
        n_total++; if (bc   !== 5)     begin n_bad++; $display("FAIL basic_busy_cycles got=%0d exp=5", bc); end
        n_total++; if (q    !== 4'd4)  begin n_bad++; $display("FAIL basic_quot got=%0d exp=4", q); end
        n_total++; if (r    !== 4'd1)  begin n_bad++; $display("FAIL basic_rem got=%0d exp=1", r); end
        n_total++; if (dz   !== 1'b0)  begin n_bad++; $display("FAIL basic_dz got=%0b exp=0", dz); end
        n_total++; if (z    !== 1'b0)  begin n_bad++; $display("FAIL basic_z got=%0b exp=0", z); end
        n_total++; if (idle !== 1'b1)  begin n_bad++; $display("FAIL basic_idle_after got=%0b exp=1", idle); end
        n_total++; if (o_quot !== 4'd4) begin n_bad++; $display("FAIL basic_hold_quot got=%0d exp=4", o_quot); end
    endtask

    task automatic test_div_zero();
        int lat, bc;
        logic [W-1:0] q, r;
        logic dz, z, idle;
        do_op(4'd7, 4'd0, lat, bc, q, r, dz, z, idle);
        n_total++; if (lat !== 2)     begin n_bad++; $display("FAIL dz_latency got=%0d exp=2", lat); end
        n_total++; if (bc  !== 2)     begin n_bad++; $display("FAIL dz_busy_cycles got=%0d exp=2", bc); end
        n_total++; if (q   !== 4'd15) begin n_bad++; $display("FAIL dz_quot got=%0d exp=15", q); end
        n_total++; if (r   !== 4'd7)  begin n_bad++; $display("FAIL dz_rem got=%0d exp=7", r); end
        n_total++; if (dz  !== 1'b1)  begin n_bad++; $display("FAIL dz_flag got=%0b exp=1", dz); end
        n_total++; if (z   !== 1'b0)  begin n_bad++; $display("FAIL dz_z got=%0b exp=0", z); end
        n_total++; if (idle !== 1'b1) begin n_bad++; $display("FAIL dz_idle_after got=%0b exp=1", idle); end
    endtask

    task automatic test_boundary();
        int lat, bc;
        logic [W-1:0] q, r;
        logic dz, z, idle;
        do_op(4'd2, 4'd5, lat, bc, q, r, dz, z, idle);
        n_total++; if (q  !== 4'd0) begin n_bad++; $display("FAIL small_quot got=%0d exp=0", q); end
        n_total++; if (r  !== 4'd2) begin n_bad++; $display("FAIL small_rem got=%0d exp=2", r); end
        n_total++; if (z  !== 1'b1) begin n_bad++; $display("FAIL small_z got=%0b exp=1", z); end
        n_total++; if (dz !== 1'b0) begin n_bad++; $display("FAIL small_dz got=%0b exp=0", dz); end
        // issued straight away: back-to-back at the W+2 period
        do_op(4'd15, 4'd1, lat, bc, q, r, dz, z, idle);
        n_total++; if (lat !== 5)     begin n_bad++; $display("FAIL max_latency got=%0d exp=5", lat); end
        n_total++; if (q   !== 4'd15) begin n_bad++; $display("FAIL max_quot got=%0d exp=15", q); end
        n_total++; if (r   !== 4'd0)  begin n_bad++; $display("FAIL max_rem got=%0d exp=0", r); end
        n_total++; if (z   !== 1'b0)  begin n_bad++; $display("FAIL max_z got=%0b exp=0", z); end
    endtask

    task automatic test_start_ignored();
        int lat;
        i_start = 1'b1;
        i_a     = 4'd9;
        i_b     = 4'd2;
        tick();
        lat = 1;
        while (!o_done && lat < 20) begin
            i_a = W'($urandom_range(0, 15));
            i_b = W'($urandom_range(0, 15));
            tick();
            lat++;
        end
        n_total++; if (lat    !== 5)    begin n_bad++; $display("FAIL spam_latency got=%0d exp=5", lat); end
        n_total++; if (o_quot !== 4'd4) begin n_bad++; $display("FAIL spam_quot got=%0d exp=4", o_quot); end
        n_total++; if (o_rem  !== 4'd1) begin n_bad++; $display("FAIL spam_rem got=%0d exp=1", o_rem); end
        tick();
        n_total++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL spam_idle_busy got=%0b exp=0", o_busy); end
        i_a = 4'd6;
        i_b = 4'd3;
        tick();
        i_start = 1'b0;
        n_total++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL spam_next_accept got=%0b exp=1", o_busy); end
        n_total++; if (o_quot !== 4'd4) begin n_bad++; $display("FAIL spam_hold_in_run got=%0d exp=4", o_quot); end
        lat = 1;
        while (!o_done && lat < 20) begin
            tick();
            lat++;
        end
        n_total++; if (lat    !== 5)    begin n_bad++; $display("FAIL spam2_latency got=%0d exp=5", lat); end
        n_total++; if (o_quot !== 4'd2) begin n_bad++; $display("FAIL spam2_quot got=%0d exp=2", o_quot); end
        n_total++; if (o_rem  !== 4'd0) begin n_bad++; $display("FAIL spam2_rem got=%0d exp=0", o_rem); end
        tick();
    endtask

    task automatic test_abort();
        int lat, bc;
        logic [W-1:0] q, r;
        logic dz, z, idle;
        logic seen_done;
        i_start = 1'b1;
        i_a     = 4'd14;
        i_b     = 4'd3;
        tick();
        i_start = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got=%0b exp=0", o_busy); end
        n_total++; if (o_quot !== 4'd0) begin n_bad++; $display("FAIL abort_quot got=%0d exp=0", o_quot); end
        n_total++; if (o_rem  !== 4'd0) begin n_bad++; $display("FAIL abort_rem got=%0d exp=0", o_rem); end
        n_total++; if (o_z    !== 1'b1) begin n_bad++; $display("FAIL abort_z got=%0b exp=1", o_z); end
        n_total++; if (o_dz   !== 1'b0) begin n_bad++; $display("FAIL abort_dz got=%0b exp=0", o_dz); end
        seen_done = o_done;
        tick();
        seen_done |= o_done;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen_done |= o_done;
        end
        n_total++; if (seen_done !== 1'b0) begin n_bad++; $display("FAIL abort_no_done got=%0b exp=0", seen_done); end
        do_op(4'd14, 4'd3, lat, bc, q, r, dz, z, idle);
        n_total++; if (q !== 4'd4) begin n_bad++; $display("FAIL after_abort_quot got=%0d exp=4", q); end
        n_total++; if (r !== 4'd2) begin n_bad++; $display("FAIL after_abort_rem got=%0d exp=2", r); end
    endtask

    task automatic test_sweep();
        int lat, bc, idx, off, ai, bi, qi, ri;
        logic [W-1:0] q, r;
        logic dz, z, idle;
        logic ok;
        off = int'($urandom_range(0, 255));
        for (int i = 0; i < 256; i++) begin
            // odd stride visits every pair once in a scrambled order
            idx = (i * 37 + off) % 256;
            ai  = idx / 16;
            bi  = idx % 16;
            do_op(W'(ai), W'(bi), lat, bc, q, r, dz, z, idle);
            qi = int'(q);
            ri = int'(r);
            if (bi == 0)
                ok = (lat == 2) && (qi == 15) && (ri == ai) && (dz == 1'b1) && (z == 1'b0);
            else
                ok = (lat == 5) && (qi * bi + ri == ai) && (ri < bi) && (dz == 1'b0) && (z == (qi == 0));
            n_total++;
            if (!ok || !idle) begin
                n_bad++;
                $display("FAIL sweep_%0d_div_%0d got q=%0d r=%0d dz=%0b z=%0b lat=%0d exp q*b+r=a r<b (or q=15 r=a dz=1) lat=%0d",
                         ai, bi, qi, ri, dz, z, lat, (bi == 0) ? 2 : 5);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_total = 0;
        n_bad   = 0;
        test_reset();
        test_basic();
        test_div_zero();
        test_boundary();
        test_start_ignored();
        test_abort();
        test_sweep();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
